// File: rtl/xcorr_plot_if.sv
// Sample stream into the cross-correlation plotter.
// Master drives valid/data/last; slave answers with ready.
interface xcorr_plot_if;
    logic       s_valid;
    logic       s_ready;
    logic [7:0] s_data;
    logic       s_last;

    modport master (
        output s_valid,
        output s_data,
        output s_last,
        input  s_ready
    );

    modport slave (
        input  s_valid,
        input  s_data,
        input  s_last,
        output s_ready
    );
endinterface

// File: rtl/xcorr_plot.sv
// Cross-correlation trace renderer behind the sync generator.
// Ping-pong sample RAM, banks swap on vsync fall; 2-clk pixel pipeline.
module xcorr_plot #(
    parameter int          H_ACTIVE  = 1024,
    parameter int          V_ACTIVE  = 768,
    parameter int          GRID_STEP = 64,
    parameter logic [23:0] TRACE_RGB = 24'h00FF00,
    parameter logic [23:0] GRID_RGB  = 24'h404040,
    parameter logic [23:0] BG_RGB    = 24'h000000
) (
    input  logic        clk,
    input  logic        rst_n,
    xcorr_plot_if.slave s,
    input  logic        in_hs,
    input  logic        in_vs,
    input  logic        in_de,
    input  logic [9:0]  in_x,
    input  logic [9:0]  in_y,
    output logic        out_hs,
    output logic        out_vs,
    output logic        out_de,
    output logic [23:0] out_rgb,
    output logic        frame_miss
);
    localparam int              AW        = $clog2(H_ACTIVE);
    localparam logic [AW-1:0]   LAST_ADDR = AW'(H_ACTIVE - 1);
    localparam logic [10:0]     T_BASE    = 11'(V_ACTIVE / 2 + 128);
    localparam logic [9:0]      G_MASK    = 10'(GRID_STEP - 1);
    localparam logic [9:0]      Y_MID     = 10'(V_ACTIVE / 2);

    typedef enum logic {FILL, FULL} wr_state_e;

    wr_state_e     state_q, state_d;
    logic [AW-1:0] wr_addr_q, wr_addr_d;
    logic          disp_bank_q, disp_bank_d;
    logic          disp_valid_q, disp_valid_d;
    logic          ready_q, ready_d;
    logic          miss_q, miss_d;
    logic          we, boundary;

    logic [9:0]    x1_q, x1_d, y1_q, y1_d;
    logic          de1_q, de1_d, hs1_q, hs1_d, vs1_q, vs1_d;
    logic          dv1_q, dv1_d;
    logic          de2_q, de2_d, hs2_q, hs2_d, vs2_q, vs2_d;
    logic [23:0]   rgb_q, rgb_d;

    logic [7:0]    mem [2*H_ACTIVE];
    logic [7:0]    samp_q, prev_q;
    logic [AW:0]   rd_addr;

    logic [10:0]   ty, tp, lo, hi;
    logic          trace, grid;

    assign s.s_ready  = ready_q;
    assign frame_miss = miss_q;
    assign out_hs     = hs2_q;
    assign out_vs     = vs2_q;
    assign out_de     = de2_q;
    assign out_rgb    = rgb_q;
    assign rd_addr    = {disp_bank_q, in_x[AW-1:0]};

    // ready_q mirrors FILL, so it alone qualifies a beat
    always_comb begin
        state_d      = state_q;
        wr_addr_d    = wr_addr_q;
        disp_bank_d  = disp_bank_q;
        disp_valid_d = disp_valid_q;
        miss_d       = 1'b0;
        we           = 1'b0;
        boundary     = vs1_q & ~in_vs;
        unique case (state_q)
            FILL: begin
                if (s.s_valid && ready_q) begin
                    we        = 1'b1;
                    wr_addr_d = wr_addr_q + 1'b1;
                    if (s.s_last || wr_addr_q == LAST_ADDR)
                        state_d = FULL;
                end
                if (boundary)
                    miss_d = 1'b1;
            end
            FULL: begin
                if (boundary) begin
                    state_d      = FILL;
                    wr_addr_d    = '0;
                    disp_bank_d  = ~disp_bank_q;
                    disp_valid_d = 1'b1;
                end
            end
            default: state_d = FILL;
        endcase
        ready_d = (state_d == FILL);
    end

    always_comb begin
        x1_d  = in_x;
        y1_d  = in_y;
        de1_d = in_de;
        hs1_d = in_hs;
        vs1_d = in_vs;
        dv1_d = disp_valid_q;
        de2_d = de1_q;
        hs2_d = hs1_q;
        vs2_d = vs1_q;
        ty    = T_BASE - {3'b000, samp_q};
        tp    = T_BASE - {3'b000, prev_q};
        lo    = (ty < tp) ? ty : tp;
        hi    = (ty < tp) ? tp : ty;
        trace = dv1_q && ({1'b0, y1_q} >= lo) && ({1'b0, y1_q} <= hi);
        grid  = ((x1_q & G_MASK) == '0) || ((y1_q & G_MASK) == '0)
                || (y1_q == Y_MID);
        rgb_d = '0;
        if (de1_q)
            rgb_d = trace ? TRACE_RGB : (grid ? GRID_RGB : BG_RGB);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= FILL;
            wr_addr_q    <= '0;
            disp_bank_q  <= 1'b0;
            disp_valid_q <= 1'b0;
            ready_q      <= 1'b0;
            miss_q       <= 1'b0;
            x1_q         <= '0;
            y1_q         <= '0;
            de1_q        <= 1'b0;
            hs1_q        <= 1'b0;
            vs1_q        <= 1'b0;
            dv1_q        <= 1'b0;
            de2_q        <= 1'b0;
            hs2_q        <= 1'b0;
            vs2_q        <= 1'b0;
            rgb_q        <= '0;
        end else begin
            state_q      <= state_d;
            wr_addr_q    <= wr_addr_d;
            disp_bank_q  <= disp_bank_d;
            disp_valid_q <= disp_valid_d;
            ready_q      <= ready_d;
            miss_q       <= miss_d;
            x1_q         <= x1_d;
            y1_q         <= y1_d;
            de1_q        <= de1_d;
            hs1_q        <= hs1_d;
            vs1_q        <= vs1_d;
            dv1_q        <= dv1_d;
            de2_q        <= de2_d;
            hs2_q        <= hs2_d;
            vs2_q        <= vs2_d;
            rgb_q        <= rgb_d;
        end
    end

    // Write side always targets the bank not on screen
    always_ff @(posedge clk) begin
        if (we)
            mem[{~disp_bank_q, wr_addr_q}] <= s.s_data;
        samp_q <= mem[rd_addr];
        prev_q <= (in_x == '0) ? mem[rd_addr] : samp_q;
    end
endmodule
